// File: rtl/stream_source_pkg.sv
// Shared types, default widths and the Galois LFSR step for the stream source.
package stream_source_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} src_state_e;

  localparam int unsigned     DEF_DATA_LENGHT = 16;
  localparam int unsigned     DEF_BURST_W     = 16;
  localparam int unsigned     DEF_GAP_W       = 8;
  localparam logic [15:0]     DEF_LFSR_TAPS   = 16'hB400;
  localparam int unsigned     LFSR_MAX_W      = 64;

  // Width-agnostic: callers zero-extend to LFSR_MAX_W and truncate the result.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] data,
                                                      input logic [LFSR_MAX_W-1:0] taps);
    lfsr_next = (data >> 1) ^ (data[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/stream_source_seq.sv
// Data sequencer: holds the current word, loads a seed, advances by increment or LFSR step.
module stream_source_seq
  import stream_source_pkg::*;
#(
  parameter int unsigned            DATA_LENGHT = DEF_DATA_LENGHT,
  parameter logic [DATA_LENGHT-1:0] LFSR_TAPS   = DATA_LENGHT'(DEF_LFSR_TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [DATA_LENGHT-1:0] seed_i,
  input  logic                   mode_i,
  input  logic                   advance_i,
  output logic [DATA_LENGHT-1:0] data_o
);

  logic [DATA_LENGHT-1:0] data_q;
  logic                   mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      mode_q <= 1'b0;
    end else if (load_i) begin
      mode_q <= mode_i;
      // An all-zero LFSR state would lock up, so it is nudged to 1.
      data_q <= (mode_i && (seed_i == '0)) ? DATA_LENGHT'(1) : seed_i;
    end else if (advance_i) begin
      if (mode_q)
        data_q <= DATA_LENGHT'(lfsr_next(LFSR_MAX_W'(data_q), LFSR_MAX_W'(LFSR_TAPS)));
      else
        data_q <= data_q + DATA_LENGHT'(1);
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/stream_source.sv
// Valid/ready burst transmitter with optional idle gaps between words.
// Define STREAM_SOURCE_LFSR_EN to add pattern_sel and the LFSR data pattern.
module stream_source
  import stream_source_pkg::*;
#(
  parameter int unsigned            DATA_LENGHT = DEF_DATA_LENGHT,
  parameter int unsigned            BURST_W     = DEF_BURST_W,
  parameter int unsigned            GAP_W       = DEF_GAP_W,
  parameter logic [DATA_LENGHT-1:0] LFSR_TAPS   = DATA_LENGHT'(DEF_LFSR_TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BURST_W-1:0]     burst_len,
  input  logic [GAP_W-1:0]       gap_len,
  input  logic [DATA_LENGHT-1:0] seed,
`ifdef STREAM_SOURCE_LFSR_EN
  input  logic                   pattern_sel,
`endif
  input  logic                   o_ready,
  output logic                   o_valid,
  output logic [DATA_LENGHT-1:0] o_data,
  output logic                   busy,
  output logic                   done,
  output logic [BURST_W-1:0]     words_sent
);

  src_state_e       state_q;
  logic [BURST_W-1:0] remaining_q;
  logic [BURST_W-1:0] words_sent_q;
  logic [GAP_W-1:0]   gap_len_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               o_valid_q;
  logic               busy_q;
  logic               done_q;

  logic xfer;
  logic load;
  logic mode;

  assign xfer = (state_q == SEND) && o_valid_q && o_ready;
  assign load = (state_q == IDLE) && start && (burst_len != '0);

`ifdef STREAM_SOURCE_LFSR_EN
  assign mode = pattern_sel;
`else
  // Tied low so the sequencer's LFSR path folds away.
  assign mode = 1'b0;
`endif

  stream_source_seq #(
    .DATA_LENGHT (DATA_LENGHT),
    .LFSR_TAPS   (LFSR_TAPS)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .seed_i    (seed),
    .mode_i    (mode),
    .advance_i (xfer),
    .data_o    (o_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      words_sent_q <= '0;
      gap_len_q    <= '0;
      gap_cnt_q    <= '0;
      o_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            words_sent_q <= '0;
            remaining_q  <= burst_len;
            gap_len_q    <= gap_len;
            busy_q       <= 1'b1;
            if (burst_len != '0) begin
              state_q   <= SEND;
              o_valid_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (xfer) begin
            words_sent_q <= words_sent_q + BURST_W'(1);
            remaining_q  <= remaining_q - BURST_W'(1);
            if (remaining_q == BURST_W'(1)) begin
              state_q   <= DONE;
              o_valid_q <= 1'b0;
              done_q    <= 1'b1;
            end else if (gap_len_q != '0) begin
              state_q   <= GAP;
              o_valid_q <= 1'b0;
              gap_cnt_q <= gap_len_q;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(1)) begin
            state_q   <= SEND;
            o_valid_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          o_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid    = o_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_sent = words_sent_q;

endmodule
